// File: rtl/glyph_pkg.sv
// Shared constants for the glyph pixel renderer: glyph geometry, glyph codes
// and VGA coordinate width.
package glyph_pkg;

    localparam int unsigned GLYPH_W = 5;
    localparam int unsigned GLYPH_H = 5;
    localparam int unsigned COORD_W = 10;

    typedef enum logic [3:0] {
        G_PLUS  = 4'd10,
        G_MINUS = 4'd11,
        G_MULT  = 4'd12,
        G_DIV   = 4'd13,
        G_BLANK = 4'd15
    } glyph_code_e;

endpackage

// File: rtl/glyph_pixel_renderer_sync_delay2.sv
// Two-stage delay for {hsync, vsync, video_on}; the visible flag is tapped
// after stage 1, the syncs leave after stage 2 to line up with the pixels.
module sync_delay2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sync_in,
    output logic       video_on_d1,
    output logic       hsync_out,
    output logic       vsync_out
);

    logic [2:0] stage1;
    logic [1:0] stage2;

    // video_on has no consumer after stage 1, so stage 2 holds only the syncs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage1 <= 3'b110;
            stage2 <= 2'b11;
        end else begin
            stage1 <= sync_in;
            stage2 <= stage1[2:1];
        end
    end

    assign video_on_d1 = stage1[0];
    assign hsync_out   = stage2[1];
    assign vsync_out   = stage2[0];

endmodule

// File: rtl/glyph_pixel_renderer.sv
// Two-stage 5x5 glyph-to-VGA pixel renderer with a per-frame glyph latch.
// Optional blink (64-frame period) is enabled by defining GLYPH_BLINK_EN.
module glyph_pixel_renderer
    import glyph_pkg::*;
#(
    parameter logic [COORD_W-1:0] X0         = 10'd304,
    parameter logic [COORD_W-1:0] Y0         = 10'd224,
    parameter int unsigned        SCALE_LOG2 = 3,
    parameter logic [7:0]         FG_RGB     = 8'hFF,
    parameter logic [7:0]         BG_RGB     = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic               video_on,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [3:0]         glyph_sel,
    output logic [3:0]         glyph_idx,
    output logic [2:0]         row_idx,
    input  logic [4:0]         rom_code,
    output logic               pixel_on,
    output logic [7:0]         rgb,
    output logic               hsync_out,
    output logic               vsync_out
);

    localparam logic [COORD_W:0] BOX_W = COORD_W'(GLYPH_W << SCALE_LOG2);
    localparam logic [COORD_W:0] BOX_H = COORD_W'(GLYPH_H << SCALE_LOG2);

    logic [COORD_W:0] px_w, py_w, x_lo, y_lo, dx, dy;
    logic             in_box;
    logic [2:0]       col_d1;
    logic             in_box_d1;
    logic             video_on_d1;
    logic             vsync_prev;
    logic             vsync_fall;
    logic             col_bit;
    logic             blink_off;
    logic             pixel_on_next;

    // 11-bit compare so the box edges never wrap near the screen limits
    assign px_w   = {1'b0, pixel_x};
    assign py_w   = {1'b0, pixel_y};
    assign x_lo   = {1'b0, X0};
    assign y_lo   = {1'b0, Y0};
    assign dx     = px_w - x_lo;
    assign dy     = py_w - y_lo;
    assign in_box = (px_w >= x_lo) && (px_w < x_lo + BOX_W) &&
                    (py_w >= y_lo) && (py_w < y_lo + BOX_H);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_idx   <= '0;
            col_d1    <= '0;
            in_box_d1 <= 1'b0;
        end else begin
            row_idx   <= in_box ? 3'(dy >> SCALE_LOG2) : '0;
            col_d1    <= 3'(dx >> SCALE_LOG2);
            in_box_d1 <= in_box;
        end
    end

    sync_delay2 u_sync_delay2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .sync_in     ({hsync_in, vsync_in, video_on}),
        .video_on_d1 (video_on_d1),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out)
    );

    assign vsync_fall = vsync_prev & ~vsync_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_prev <= 1'b1;
            glyph_idx  <= '0;
        end else begin
            vsync_prev <= vsync_in;
            if (vsync_fall)
                glyph_idx <= glyph_sel;
        end
    end

`ifdef GLYPH_BLINK_EN
    logic [5:0] blink_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            blink_cnt <= '0;
        else if (vsync_fall)
            blink_cnt <= blink_cnt + 6'd1;
    end

    assign blink_off = blink_cnt[5];
`else
    assign blink_off = 1'b0;
`endif

    // Bit 4 is the leftmost column; columns past the glyph read as off
    always_comb begin
        col_bit = 1'b0;
        case (col_d1)
            3'd0:    col_bit = rom_code[4];
            3'd1:    col_bit = rom_code[3];
            3'd2:    col_bit = rom_code[2];
            3'd3:    col_bit = rom_code[1];
            3'd4:    col_bit = rom_code[0];
            default: col_bit = 1'b0;
        endcase
    end

    assign pixel_on_next = in_box_d1 & video_on_d1 & col_bit & ~blink_off;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel_on <= 1'b0;
            rgb      <= BG_RGB;
        end else begin
            pixel_on <= pixel_on_next;
            rgb      <= pixel_on_next ? FG_RGB : (video_on_d1 ? BG_RGB : 8'h00);
        end
    end

endmodule
